sequenciador_mapas: RTL
=======================

// Module: sequenciador_mapas
// PURPOSE
//  Buffers robot pose + side-distance samples arriving from the sensor/odometry side and
//  feeds them one at a time into the occupancy-grid builder (mapas). It owns the
//  novoDado/operacaoFinalizada handshake, so producers never stall on a grid update.
//  It also drops malformed samples and runs a watchdog on mapas. Sits between the
//  sensor front-end and mapas.
// PARAMETERS
//  TamanhoMalha      9     grid side in cells; valid coordinates are 0..TamanhoMalha-1
//  tamanhoDistancia  4     width of position/distance fields
//  PROFUNDIDADE      4     sample FIFO depth, power of 2, >=2
//  TIMEOUT           1024  max cycles waiting on mapas per phase before abort
// PORTS
//  clock               in   1    rising-edge clock
//  reset               in   1    synchronous, active-low
//  in_valido           in   1    producer sample valid
//  in_pronto           out  1    FIFO can accept (= !cheio)
//  in_x, in_y          in   tD   sample position (tD = tamanhoDistancia)
//  in_direcao          in   1    sample heading
//  in_distDir          in   tD   right distance
//  in_distEsq          in   tD   left distance
//  posicaoAtualnoEixoX out  tD   to mapas, held stable while novoDado or mapas busy
//  posicaoAtualnoEixoY out  tD   to mapas
//  direcaoAtual        out  1    to mapas
//  distanciaDireita    out  tD   to mapas
//  distanciaEsquerda   out  tD   to mapas
//  novoDado            out  1    request to mapas
//  operacaoFinalizada  in   1    from mapas: 1 = idle/done, 0 = busy
//  ocupado             out  1    FSM not in OCIOSO or FIFO not empty
//  nivel_fila          out  $clog2(PROFUNDIDADE)+1  current FIFO occupancy
//  atualizacoes        out  16   completed updates, wraps at 0xFFFF->0
//  descartes           out  8    out-of-range samples dropped, saturates at 255
//  erro_timeout        out  1    sticky; cleared only by reset
// BEHAVIOUR
//  Reset (reset==0 at posedge): all outputs 0, FIFO emptied, FSM->OCIOSO, counters 0.
//    Applies mid-operation: novoDado drops next cycle and the in-flight sample is lost.
//  Push: the sample is taken when in_valido && in_pronto.
//    If in_x or in_y >= TamanhoMalha: not stored; descartes increments (saturating).
//  FIFO: push and pop in the same cycle are both allowed, including when full.
//    Full: in_pronto=0; a push and pop in the same cycle while full is accepted.
//    Pointers wrap modulo PROFUNDIDADE.
//  FSM:
//   OCIOSO: if FIFO not empty && operacaoFinalizada==1, pop head into output regs -> REQUISITA.
//   REQUISITA: novoDado=1 and outputs held. Go to ESPERA_FIM when operacaoFinalizada==0
//     (mapas acked). novoDado goes 0 the cycle after the ack is seen.
//   ESPERA_FIM: novoDado=0. When operacaoFinalizada==1: atualizacoes+1 -> OCIOSO.
//   Watchdog: counter reset on each state entry, counts in REQUISITA/ESPERA_FIM.
//     On reaching TIMEOUT: erro_timeout=1, novoDado=0, sample abandoned
//     (atualizacoes unchanged), FSM -> OCIOSO.
//  Latency: sample pushed into an empty FIFO with mapas idle -> novoDado=1 two cycles
//    after the push edge (one cycle for the FIFO write, one for the pop/load).
//  Data outputs change only on the OCIOSO pop; otherwise they keep the last sample.
//  No stall on erro_timeout: the next sample is processed normally.
// STRUCTURE
//  Shared package mapas_pkg:
//    - typedef amostra_t (x, y, direcao, distDir, distEsq; widths from tamanhoDistancia)
//    - FSM enum estado_seq_t {OCIOSO, REQUISITA, ESPERA_FIM}
//  Sub-module fifo_amostras: parameterised sync FIFO of amostra_t.
//    Ports: push, pop, full, empty, count.
//  Range check, FSM, watchdog and counters live in sequenciador_mapas.
// TESTING
//  1. Reset held 3 cycles mid-REQUISITA -> all outputs 0, nivel_fila=0, no further novoDado.
//  2. Push (x=2,y=0,dir=0,dD=0,dE=1) with a mapas model acking after 3 cycles and done
//     after 10 -> novoDado high exactly until the ack; outputs = sample; atualizacoes=1.
//  3. Push 6 back-to-back with PROFUNDIDADE=4 and mapas busy -> in_pronto low after 4,
//     order preserved, atualizacoes=4 once the FIFO drains.
//  4. Push x=9 (TamanhoMalha=9) then x=8 -> descartes=1, only x=8 reaches mapas.
//  5. Model never drops operacaoFinalizada, TIMEOUT=16 -> erro_timeout=1 at cycle 16 of
//     REQUISITA, novoDado=0, next queued sample still issued.
//  6. Simultaneous push+pop while full -> nivel_fila unchanged, no sample lost or duplicated.

Source files
------------

// File: rtl/mapas_pkg.sv
// Types shared by the sample path into the occupancy-grid builder (mapas):
// the buffered pose/distance sample and the issue FSM states.
package mapas_pkg;

  localparam int LARG_DIST = 4;

  typedef struct packed {
    logic [LARG_DIST-1:0] x;
    logic [LARG_DIST-1:0] y;
    logic                 direcao;
    logic [LARG_DIST-1:0] distDir;
    logic [LARG_DIST-1:0] distEsq;
  } amostra_t;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    REQUISITA  = 2'd1,
    ESPERA_FIM = 2'd2
  } estado_seq_t;

  function automatic logic dentro_malha(input logic [LARG_DIST-1:0] x,
                                        input logic [LARG_DIST-1:0] y,
                                        input int                   tam);
    return (int'(x) < tam) && (int'(y) < tam);
  endfunction

endpackage

// File: rtl/fifo_amostras.sv
// Sync FIFO of samples, head visible combinationally; one-cycle write latency.
// A push while full is taken only when a pop happens in the same cycle.
module fifo_amostras
  import mapas_pkg::*;
#(
  parameter  int PROFUNDIDADE = 4,
  localparam int AW           = $clog2(PROFUNDIDADE),
  localparam int CW           = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  amostra_t      dado_in,
  input  logic          pop,
  output amostra_t      dado_out,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  amostra_t      r_mem [PROFUNDIDADE];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full     = (r_count == CW'(PROFUNDIDADE));
  assign empty    = (r_count == '0);
  assign w_pop    = pop && !empty;
  assign w_push   = push && (!full || w_pop);
  assign count    = r_count;
  assign dado_out = r_mem[r_rd];

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= dado_in;
  end

endmodule

// File: rtl/sequenciador_mapas.sv
// Queues pose/distance samples and issues them one at a time to mapas; novoDado rises
// two cycles after a push into an idle path. Producer stalls only when the FIFO is full.
module sequenciador_mapas
  import mapas_pkg::*;
#(
  parameter  int TamanhoMalha     = 9,
  parameter  int tamanhoDistancia = LARG_DIST,
  parameter  int PROFUNDIDADE     = 4,
  parameter  int TIMEOUT          = 1024,
  localparam int NW               = $clog2(PROFUNDIDADE) + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valido,
  output logic                        in_pronto,
  input  logic [tamanhoDistancia-1:0] in_x,
  input  logic [tamanhoDistancia-1:0] in_y,
  input  logic                        in_direcao,
  input  logic [tamanhoDistancia-1:0] in_distDir,
  input  logic [tamanhoDistancia-1:0] in_distEsq,
  output logic [tamanhoDistancia-1:0] posicaoAtualnoEixoX,
  output logic [tamanhoDistancia-1:0] posicaoAtualnoEixoY,
  output logic                        direcaoAtual,
  output logic [tamanhoDistancia-1:0] distanciaDireita,
  output logic [tamanhoDistancia-1:0] distanciaEsquerda,
  output logic                        novoDado,
  input  logic                        operacaoFinalizada,
  output logic                        ocupado,
  output logic [NW-1:0]               nivel_fila,
  output logic [15:0]                 atualizacoes,
  output logic [7:0]                  descartes,
  output logic                        erro_timeout
);

  localparam int WW = $clog2(TIMEOUT + 1);

  estado_seq_t   r_estado;
  estado_seq_t   w_prox;
  amostra_t      r_amostra;
  amostra_t      w_nova;
  amostra_t      w_cabeca;
  logic          w_cheio;
  logic          w_vazio;
  logic          w_aceita;
  logic          w_valida;
  logic          w_push;
  logic          w_pop;
  logic          w_conclui;
  logic          w_aborta;
  logic          w_estouro;
  logic [WW-1:0] r_wd;
  logic [15:0]   r_atualizacoes;
  logic [7:0]    r_descartes;
  logic          r_erro;

  assign w_nova   = '{x: in_x, y: in_y, direcao: in_direcao,
                      distDir: in_distDir, distEsq: in_distEsq};
  assign w_aceita = in_valido && in_pronto;
  assign w_valida = dentro_malha(in_x, in_y, TamanhoMalha);
  assign w_push   = w_aceita && w_valida;
  // A full FIFO still takes a sample in the cycle its head is being popped.
  assign in_pronto = !w_cheio || w_pop;

  fifo_amostras #(.PROFUNDIDADE(PROFUNDIDADE)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (w_push),
    .dado_in  (w_nova),
    .pop      (w_pop),
    .dado_out (w_cabeca),
    .full     (w_cheio),
    .empty    (w_vazio),
    .count    (nivel_fila)
  );

  assign w_estouro = (r_wd == WW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset) r_estado <= OCIOSO;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox    = r_estado;
    w_pop     = 1'b0;
    w_conclui = 1'b0;
    w_aborta  = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (!w_vazio && operacaoFinalizada) begin
          w_pop  = 1'b1;
          w_prox = REQUISITA;
        end
      end
      REQUISITA: begin
        if (!operacaoFinalizada) begin
          w_prox = ESPERA_FIM;
        end else if (w_estouro) begin
          w_aborta = 1'b1;
          w_prox   = OCIOSO;
        end
      end
      ESPERA_FIM: begin
        if (operacaoFinalizada) begin
          w_conclui = 1'b1;
          w_prox    = OCIOSO;
        end else if (w_estouro) begin
          w_aborta = 1'b1;
          w_prox   = OCIOSO;
        end
      end
      default: w_prox = OCIOSO;
    endcase
  end

  // Watchdog restarts on every state change, so each mapas phase gets its own budget.
  always_ff @(posedge clock) begin
    if (!reset)                                        r_wd <= '0;
    else if ((w_prox != r_estado) || (r_estado == OCIOSO)) r_wd <= '0;
    else                                               r_wd <= r_wd + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_amostra      <= '0;
      r_atualizacoes <= '0;
      r_descartes    <= '0;
      r_erro         <= 1'b0;
    end else begin
      if (w_pop)     r_amostra      <= w_cabeca;
      if (w_conclui) r_atualizacoes <= r_atualizacoes + 16'd1;
      if (w_aceita && !w_valida && (r_descartes != 8'hFF))
        r_descartes <= r_descartes + 8'd1;
      if (w_aborta)  r_erro         <= 1'b1;
    end
  end

  assign novoDado            = (r_estado == REQUISITA);
  assign ocupado             = (r_estado != OCIOSO) || !w_vazio;
  assign posicaoAtualnoEixoX = r_amostra.x;
  assign posicaoAtualnoEixoY = r_amostra.y;
  assign direcaoAtual        = r_amostra.direcao;
  assign distanciaDireita    = r_amostra.distDir;
  assign distanciaEsquerda   = r_amostra.distEsq;
  assign atualizacoes        = r_atualizacoes;
  assign descartes           = r_descartes;
  assign erro_timeout        = r_erro;

endmodule
